// File: rtl/serial_subtractor_ctrl_pkg.sv
// Shared definitions for the bit-serial subtractor controller.
package serial_subtractor_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: D = X - Y - Bin, B = borrow out.
module full_subtractor (
  input  logic X,
  input  logic Y,
  input  logic Bin,
  output logic D,
  output logic B
);

  logic hs1Diff;
  logic hs1Borrow;
  logic hs2Borrow;

  // Two half-subtractor cells chained, their borrows merged by an OR.
  assign hs1Diff   = X ^ Y;
  assign hs1Borrow = ~X & Y;
  assign D         = hs1Diff ^ Bin;
  assign hs2Borrow = ~hs1Diff & Bin;
  assign B         = hs1Borrow | hs2Borrow;

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial subtractor: one full-subtract step per cycle, LSB first.
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             B,
  output logic             Z,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             borrow_q, borrow_d;
  logic             b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             fsDiff;
  logic             fsBorrow;
  logic             lastBit;

  full_subtractor u_fs (
    .X   (x_q[0]),
    .Y   (y_q[0]),
    .Bin (borrow_q),
    .D   (fsDiff),
    .B   (fsBorrow)
  );

  assign lastBit = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    res_d    = res_q;
    d_d      = d_q;
    borrow_d = borrow_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d      = X;
          y_d      = Y;
          borrow_d = Bin;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        x_d      = x_q >> 1;
        y_d      = y_q >> 1;
        res_d    = {fsDiff, res_q[WIDTH-1:1]};
        borrow_d = fsBorrow;
        cnt_d    = cnt_q + CW'(1);
        // Outputs are only published on the edge that finishes the last bit.
        if (lastBit) begin
          d_d     = {fsDiff, res_q[WIDTH-1:1]};
          b_d     = fsBorrow;
          state_d = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          x_d      = X;
          y_d      = Y;
          borrow_d = Bin;
          cnt_d    = '0;
          state_d  = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      res_q    <= '0;
      d_q      <= '0;
      borrow_q <= 1'b0;
      b_q      <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      res_q    <= res_d;
      d_q      <= d_d;
      borrow_q <= borrow_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
    end
  end

  assign D = d_q;
  assign B = b_q;
  assign Z = (d_q == '0);

endmodule

// File: doc/serial_subtractor_ctrl.md
SERIAL_SUBTRACTOR_CTRL -- requirements
Module: serial_subtractor_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin one subtraction; sampled on the rising clk edge.
REQ-005 SHALL have port X  input  WIDTH  minuend, captured when start is accepted.
REQ-006 SHALL have port Y  input  WIDTH  subtrahend, captured when start is accepted.
REQ-007 SHALL have port Bin  input  1  borrow-in, captured when start is accepted.
REQ-008 SHALL have port D  output  WIDTH  difference (X - Y - Bin) mod 2^WIDTH.
REQ-009 SHALL have port B  output  1  final borrow-out; 1 iff X < Y + Bin (unsigned).
REQ-010 SHALL have port Z  output  1  zero flag; 1 iff D == 0.
REQ-011 SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse marking D, B, Z valid.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT and DONE.
REQ-014 IDLE: start=1 SHALL capture X, Y and Bin into internal shift/borrow registers, clear the bit counter and move to SHIFT; start=0 SHALL remain in IDLE.
REQ-015 SHIFT: each cycle SHALL apply one 1-bit full-subtract step, LSB first, on the current operand LSBs and the borrow register.
REQ-016 SHIFT: each cycle SHALL shift the difference bit into the result register MSB-side, update the borrow register and increment the counter.
REQ-017 SHALL leave SHIFT for DONE after exactly WIDTH SHIFT cycles, i.e. on the edge that processes bit WIDTH-1.
REQ-018 DONE SHALL last one cycle with done=1; D, B and Z SHALL be valid during that cycle.
REQ-019 DONE SHALL go to SHIFT if start=1 (new operands captured, back-to-back operation), else to IDLE.
REQ-020 Latency: done SHALL be high exactly WIDTH+1 clk edges after the edge that accepted start.
REQ-021 busy SHALL be 1 in SHIFT and 0 in IDLE and DONE.
REQ-022 start SHALL be ignored in SHIFT; operands and results SHALL be unaffected.
REQ-023 D, B and Z SHALL hold the last completed result through IDLE and SHIFT, and SHALL change only on entry to DONE.
REQ-024 D and B SHALL be registered outputs; Z SHALL be derived from registered D.
REQ-025 Arithmetic SHALL be unsigned modulo 2^WIDTH.
REQ-026 The counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within one operation.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, counter 0, borrow register 0, D=0, B=0, busy=0, done=0 and Z=1, regardless of clk.
REQ-028 rst asserted mid-SHIFT SHALL abort the operation with no done pulse; the next start after rst is released SHALL run a full WIDTH+1-cycle operation.

Structure
REQ-029 SHALL place the FSM state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) in a shared package/include file; WIDTH SHALL remain a module parameter.
REQ-030 SHALL instantiate one sub-module, full_subtractor (X, Y, Bin -> D, B), built from two half-subtractor cells plus an OR of their borrows.
REQ-031 full_subtractor SHALL be the only arithmetic in the block.

Verification (WIDTH=8)
REQ-032 X=0x05, Y=0x03, Bin=0, start pulse -> done 9 edges later, D=0x02, B=0, Z=0; busy high for 8 cycles.
REQ-033 X=0x03, Y=0x05, Bin=0 -> D=0xFE, B=1, Z=0; X=0x00, Y=0x00, Bin=1 -> D=0xFF, B=1; X=0x7A, Y=0x7A, Bin=0 -> D=0x00, B=0, Z=1.
REQ-034 Start X=0x10, Y=0x01, then re-assert start with X=0xFF, Y=0xFF at SHIFT cycle 3 -> second start ignored, result D=0x0F, B=0.
REQ-035 start held high continuously with X=0x20, Y=0x01 -> done pulses every 9 cycles, D=0x1F each time, busy low only in DONE cycles.
REQ-036 rst asserted at SHIFT cycle 4, between clk edges -> busy=0, D=0x00, Z=1 immediately; no done pulse follows; a new start then completes normally.
